// File: rtl/pipe_seg_elastic.sv
// rtl/pipe_seg_elastic.sv - elastic valid/ready pipeline segment register with optional skid entry
module pipe_seg_elastic #(
  parameter int W        = 32,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic         mv;
  logic         sv;
  logic [W-1:0] md;

  assign out_valid = mv;
  assign out_data  = md;
  assign occupancy = {mv & sv, mv ^ sv};

  generate
    if (SKID != 0) begin : g_skid
      logic [W-1:0] sd;
      logic         free_q;
      logic         in_fire;
      logic         out_fire;

      // free_q mirrors !sv; the resetn gate keeps in_ready low while reset is held
      assign in_ready = resetn & free_q;
      assign in_fire  = in_valid & in_ready;
      assign out_fire = mv & out_ready;

      always_ff @(posedge clk) begin
        if (!resetn || flush) begin
          mv     <= 1'b0;
          sv     <= 1'b0;
          free_q <= 1'b1;
          if (CLR_DATA != 0) begin
            md <= '0;
            sd <= '0;
          end
        end else if (out_fire && sv) begin
          md     <= sd;
          sv     <= 1'b0;
          free_q <= 1'b1;
        end else if (out_fire) begin
          if (in_fire) md <= in_data;
          else         mv <= 1'b0;
        end else if (!mv) begin
          if (in_fire) begin
            md <= in_data;
            mv <= 1'b1;
          end
        end else if (in_fire) begin
          sd     <= in_data;
          sv     <= 1'b1;
          free_q <= 1'b0;
        end
      end
    end else begin : g_noskid
      assign sv       = 1'b0;
      assign in_ready = resetn & (!mv | out_ready);

      always_ff @(posedge clk) begin
        if (!resetn || flush) begin
          mv <= 1'b0;
          if (CLR_DATA != 0) md <= '0;
        end else if (in_ready) begin
          md <= in_data;
          mv <= in_valid;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (mv && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_seg_elastic.sv
// tb/tb_pipe_seg_elastic.sv - scoreboard bench for pipe_seg_elastic in skid and non-skid modes
module tb_pipe_seg_elastic;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = 32'h0;

  logic        ov  [2];
  logic        ir  [2];
  logic [31:0] od  [2];
  logic [1:0]  occ [2];
  logic [15:0] sc  [2];
  logic [3:0]  sc1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  assign sc[1] = {12'h0, sc1};

  pipe_seg_elastic #(.W(32), .SKID(1), .CLR_DATA(1), .CNT_W(16)) u_skid (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(occ[0]), .stall_cnt(sc[0])
  );

  pipe_seg_elastic #(.W(32), .SKID(0), .CLR_DATA(1), .CNT_W(4)) u_reg (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(occ[1]), .stall_cnt(sc1)
  );

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rn, input logic fl, input logic iv,
                       input logic [31:0] d, input logic ordy);
    @(posedge clk);
    #1;
    resetn    = rn;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  // Reference: a FIFO of accepted payloads; held entries = queue length
  for (genvar k = 0; k < 2; k++) begin : sb
    localparam int SMAX = (k == 0) ? 65535 : 15;
    logic [31:0] q[$];
    int st = 0;

    always @(negedge clk) begin
      int   n;
      logic exp_ir;
      n = q.size();
      if (mon_en && !resetn) begin
        chk("in_ready_rst", k, ir[k], 0);
      end else if (mon_en) begin
        exp_ir = (k == 0) ? (n < 2) : (n == 0 || out_ready);
        chk("out_valid", k, ov[k], n > 0);
        chk("occupancy", k, occ[k], n);
        chk("in_ready", k, ir[k], exp_ir);
        chk("stall_cnt", k, sc[k], st);
        if (n > 0) begin
          chk("out_data", k, od[k], q[0]);
          if (out_ready) void'(q.pop_front());
          else if (st < SMAX) st++;
        end
      end
    end

    always @(negedge clk) begin
      #1;
      if (!resetn) begin
        q.delete();
        st = 0;
      end else if (flush) begin
        q.delete();
      end else if (in_valid && ir[k]) begin
        q.push_back(in_data);
      end
    end
  end

  initial begin
    repeat (3) drive(0, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 32'h0, 0);
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 0, ov[0], 0);
    chk("rst_out_data", 0, od[0], 0);
    chk("rst_out_data", 1, od[1], 0);
    chk("rst_occupancy", 0, occ[0], 0);
    chk("rst_in_ready", 0, ir[0], 1);
    chk("rst_stall_cnt", 0, sc[0], 0);

    foreach (sb[0].q[i]) ;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 1, 32'h11 * i, 1);
      @(negedge clk);
      chk("stream_in_ready", 0, ir[0], 1);
    end
    drive(1, 0, 0, 32'h0, 1);

    drive(1, 0, 1, 32'hA, 0);
    drive(1, 0, 1, 32'hB, 0);
    drive(1, 0, 0, 32'h0, 0);
    @(negedge clk);
    chk("bp_occupancy", 0, occ[0], 2);
    chk("bp_in_ready", 0, ir[0], 0);
    chk("bp_hold_data", 0, od[0], 32'hA);
    drive(1, 0, 0, 32'h0, 1);
    @(negedge clk);
    chk("bp_first_out", 0, od[0], 32'hA);
    drive(1, 0, 0, 32'h0, 1);
    @(negedge clk);
    chk("bp_second_out", 0, od[0], 32'hB);
    chk("bp_in_ready_back", 0, ir[0], 1);

    drive(1, 0, 1, 32'hC, 0);
    drive(1, 0, 1, 32'hD, 0);
    drive(1, 1, 1, 32'hE, 0);
    drive(1, 0, 0, 32'h0, 0);
    @(negedge clk);
    chk("flush_out_valid", 0, ov[0], 0);
    chk("flush_occupancy", 0, occ[0], 0);
    chk("flush_out_data", 0, od[0], 0);
    chk("flush_out_data", 1, od[1], 0);

    drive(1, 0, 1, 32'h7, 0);
    drive(1, 0, 0, 32'h0, 0);
    @(negedge clk);
    chk("reg_in_ready_blocked", 1, ir[1], 0);
    drive(1, 0, 1, 32'h5, 1);
    @(negedge clk);
    chk("reg_in_ready_open", 1, ir[1], 1);
    drive(1, 0, 0, 32'h0, 0);
    @(negedge clk);
    chk("reg_out_valid", 1, ov[1], 1);
    chk("reg_out_data", 1, od[1], 32'h5);

    repeat (20) drive(1, 0, 0, 32'h0, 0);
    @(negedge clk);
    chk("sat_stall_cnt", 1, sc[1], 15);
    drive(1, 0, 0, 32'h0, 0);
    @(negedge clk);
    chk("sat_stall_hold", 1, sc[1], 15);
    drive(0, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 32'h0, 0);
    @(negedge clk);
    chk("sat_reset_clear", 1, sc[1], 0);
    chk("sat_reset_clear", 0, sc[0], 0);

    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 9) < 6));
    end
    repeat (6) drive(1, 0, 0, 32'h0, 1);
    @(negedge clk);
    #2;
    chk("drain_empty", 0, sb[0].q.size(), 0);
    chk("drain_empty", 1, sb[1].q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_seg_elastic.md
Name: pipe_seg_elastic

Overview:
- Generic, parametrised inter-stage pipeline register that replaces the hand-written per-stage segment registers (IF/ID, ID/EX, EX/EC, ...).
- Uses a valid/ready handshake instead of a global stall.
- Has an optional 2-entry skid buffer, so upstream ready is a registered signal that does not depend on downstream ready.
- Provides flush (refresh) and a saturating stall-cycle counter for performance analysis.
- The stage payload is a packed bus; each pipeline boundary is one instance with its own W.

Parameters:
- W, 32: payload width in bits, legal range 1..1024.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLR_DATA, 1: 1 = reset and flush zero the payload registers; 0 = reset and flush clear only the valid bits.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- flush  in  1  discard all held entries (exception, eret or branch refresh).
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  block accepts a payload this cycle.
- in_data  in  W  upstream payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  W  downstream payload.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:

State:
- Main entry M: mv and md. out_valid=mv, out_data=md.
- Skid entry S: sv and sd. Present only when SKID=1; when SKID=0, sv is a constant 0.
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.

Reset (resetn=0 at a clock edge):
- mv=0, sv=0, stall_cnt=0, in_ready=0 during reset.
- md and sd = 0 when CLR_DATA=1; otherwise unchanged.
- First cycle after reset: in_ready=1, out_valid=0, occupancy=0.

Flush (resetn=1, flush=1), priority over all other updates:
- mv<=0, sv<=0.
- Payloads zeroed when CLR_DATA=1.
- A payload handshaken in the flush cycle is consumed and discarded; it never appears at the output.
- out_fire in the flush cycle still counts as delivered.
- stall_cnt is NOT cleared by flush.

SKID=1 (in_ready = !sv, driven directly from a flop):
- out_fire & sv: M<=S, sv<=0. in_fire is impossible in this case.
- out_fire & !sv & in_fire: M<=in_data, mv stays 1.
- out_fire & !sv & !in_fire: mv<=0.
- !mv & in_fire: M<=in_data, mv<=1. sv is 0 by invariant.
- mv & !out_ready & in_fire: S<=in_data, sv<=1, so in_ready=0 next cycle.
- Invariant: sv=1 implies mv=1.
- Latency: 1 cycle from in_fire to out_valid when empty.
- Throughput: 1 per cycle with out_ready held high.

SKID=0:
- in_ready = !mv | out_ready (combinational).
- When in_ready=1: md<=in_data, mv<=in_valid.
- Otherwise hold.

Ordering and integrity (both modes):
- Strict FIFO order; no loss, duplication or reordering.
- out_data is held stable while out_valid=1 and out_ready=0.

occupancy:
- Equals mv+sv, registered-derived with no combinational input path.

stall_cnt:
- Increments when out_valid & !out_ready.
- Holds at 2^CNT_W-1 once reached.
- Cleared only by reset.

Simultaneous events:
- Reset beats flush; flush beats handshakes.
- Reset asserted mid-transfer drops both entries with no output.

Test Plan:
- Reset with CLR_DATA=1, W=32: hold resetn=0 for 3 cycles, release -> out_valid=0, out_data=0, occupancy=0, in_ready=1, stall_cnt=0.
- Streaming, SKID=1: drive 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=1 -> outputs appear in order, one per cycle, 1-cycle latency, in_ready stays 1.
- Backpressure, SKID=1: send 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA, then 0xB; in_ready returns to 1 the cycle after 0xA leaves. stall_cnt counts the stalled cycles exactly.
- Flush with skid full: occupancy=2, assert flush with in_valid=1 for 1 cycle -> next cycle out_valid=0, occupancy=0, out_data=0; the flushed input never appears; stall_cnt unchanged.
- SKID=0 mode: out_ready=0 with mv=1 -> in_ready=0 in the same cycle. Raise out_ready with in_valid=1 and in_data=0x5 -> 0x5 is accepted the same cycle and appears next cycle.
- Counter saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reads 15 and stays 15; reset returns it to 0.
